// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: 2-entry skid queue between IF and ID/EX with opcode pre-decode.
// Optional performance counters are built when ID_ISSUE_PERF_EN is defined.

package id_issue_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

module id_issue_ctrl
    import id_issue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output imm_src_e        out_imm_src,
    output logic            out_illegal,
    input  logic            flush
`ifdef ID_ISSUE_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cycles,
    output logic [CNT_W-1:0] perf_flushed,
    output logic [CNT_W-1:0] perf_illegal
`endif
);

    generate
        if (XLEN != 32 || DEPTH != 2 || CNT_W < 2) begin : g_bad_param
            $error("id_issue_ctrl: only XLEN=32, DEPTH=2 and CNT_W>=2 are supported");
        end
    endgenerate

    // Occupancy and registered ready
    logic [1:0] count_q, count_d;
    logic       in_ready_q, in_ready_d;

    // Head entry doubles as the output register; the skid entry holds the second instruction.
    logic [XLEN-1:0] head_instr_q, head_instr_d;
    logic [XLEN-1:0] head_pc_q,    head_pc_d;
    imm_src_e        head_imm_q,   head_imm_d;
    logic            head_ill_q,   head_ill_d;

    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q,    skid_pc_d;
    imm_src_e        skid_imm_q,   skid_imm_d;
    logic            skid_ill_q,   skid_ill_d;

    logic     push;
    logic     pop;
    imm_src_e dec_imm;
    logic     dec_ill;

    assign out_valid   = (count_q != 2'd0);
    assign in_ready    = in_ready_q;
    assign out_instr   = head_instr_q;
    assign out_pc      = head_pc_q;
    assign out_imm_src = head_imm_q;
    assign out_illegal = head_ill_q;

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid && out_ready;

    // RTYPE has no immediate; IMM_I is selected as a don't-care value.
    always_comb begin
        dec_imm = IMM_I;
        dec_ill = 1'b0;
        case (in_instr[6:0])
            OP_RTYPE, OP_ITYPE, OP_LOAD, OP_JALR: dec_imm = IMM_I;
            OP_STORE:                             dec_imm = IMM_S;
            OP_BRANCH:                            dec_imm = IMM_B;
            OP_JAL:                               dec_imm = IMM_J;
            default:                              dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        head_imm_d   = head_imm_q;
        head_ill_d   = head_ill_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_imm_d   = skid_imm_q;
        skid_ill_d   = skid_ill_q;

        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_instr_d = in_instr;
                        head_pc_d    = in_pc;
                        head_imm_d   = dec_imm;
                        head_ill_d   = dec_ill;
                    end else begin
                        skid_instr_d = in_instr;
                        skid_pc_d    = in_pc;
                        skid_imm_d   = dec_imm;
                        skid_ill_d   = dec_ill;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    // Popping the last entry leaves the head untouched so outputs hold.
                    if (count_q == 2'd2) begin
                        head_instr_d = skid_instr_q;
                        head_pc_d    = skid_pc_q;
                        head_imm_d   = skid_imm_q;
                        head_ill_d   = skid_ill_q;
                    end
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_instr_d = skid_instr_q;
                        head_pc_d    = skid_pc_q;
                        head_imm_d   = skid_imm_q;
                        head_ill_d   = skid_ill_q;
                        skid_instr_d = in_instr;
                        skid_pc_d    = in_pc;
                        skid_imm_d   = dec_imm;
                        skid_ill_d   = dec_ill;
                    end else begin
                        head_instr_d = in_instr;
                        head_pc_d    = in_pc;
                        head_imm_d   = dec_imm;
                        head_ill_d   = dec_ill;
                    end
                end
                default: count_d = count_q;
            endcase
        end

        in_ready_d = (count_d < 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= 2'd0;
            in_ready_q   <= 1'b0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            head_imm_q   <= IMM_I;
            head_ill_q   <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_imm_q   <= IMM_I;
            skid_ill_q   <= 1'b0;
        end else begin
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            head_imm_q   <= head_imm_d;
            head_ill_q   <= head_ill_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_imm_q   <= skid_imm_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

`ifdef ID_ISSUE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flushed_cnt_q, illegal_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q   <= '0;
            flushed_cnt_q <= '0;
            illegal_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush) begin
                flushed_cnt_q <= flushed_cnt_q + {{(CNT_W-2){1'b0}}, count_q};
            end
            if (pop && head_ill_q) begin
                illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_flushed      = flushed_cnt_q;
    assign perf_illegal      = illegal_cnt_q;
`endif

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        {30'd0, count_q} <= DEPTH);
    a_ready_tracks_count: assert property (@(posedge clk) disable iff (!rst_n)
        in_ready_q |-> (count_q != 2'd2));

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Table-driven bench for id_issue_ctrl: directed vectors plus hand-written reset sequences.
// Expected immediates come from a small imm_extend model in the bench.

module tb_id_issue_ctrl;
    import id_issue_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    imm_src_e    out_imm_src;
    logic        out_illegal;
    logic        flush;
`ifdef ID_ISSUE_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flushed;
    logic [31:0] perf_illegal;
`endif

    int errors = 0;
    int checks = 0;

    id_issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_imm_src(out_imm_src),
        .out_illegal(out_illegal),
        .flush      (flush)
`ifdef ID_ISSUE_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flushed     (perf_flushed),
        .perf_illegal     (perf_illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic        erdy;
        logic [31:0] eins;
        logic [31:0] epc;
        imm_src_e    eimm;
        logic        eill;
        logic        chk_imm;
        logic [31:0] eimmval;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs [NV];

    function automatic vec_t mk(logic iv, logic [31:0] ins, logic [31:0] pc, logic ordy, logic fl,
                                logic ev, logic erdy, logic [31:0] eins, logic [31:0] epc,
                                imm_src_e eimm, logic eill, logic chk_imm, logic [31:0] eimmval);
        vec_t v;
        v.iv = iv; v.ins = ins; v.pc = pc; v.ordy = ordy; v.fl = fl;
        v.ev = ev; v.erdy = erdy; v.eins = eins; v.epc = epc;
        v.eimm = eimm; v.eill = eill; v.chk_imm = chk_imm; v.eimmval = eimmval;
        return v;
    endfunction

    function automatic logic [31:0] imm_extend(logic [31:0] i, imm_src_e src);
        case (src)
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            IMM_J:   return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            default: return {{20{i[31]}}, i[31:20]};
        endcase
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d actual=0x%08h expected=0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(logic iv, logic [31:0] ins, logic [31:0] pc, logic ordy, logic fl);
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        // Basic issue path: one instruction per cycle with immediates checked via the model.
        vecs[0]  = mk(1, 32'h00508113, 32'h00, 1, 0, 1, 1, 32'h00508113, 32'h00, IMM_I, 0, 1, 32'h05);
        vecs[1]  = mk(1, 32'h0430AA23, 32'h04, 1, 0, 1, 1, 32'h0430AA23, 32'h04, IMM_S, 0, 1, 32'h54);
        vecs[2]  = mk(1, 32'h00208463, 32'h08, 1, 0, 1, 1, 32'h00208463, 32'h08, IMM_B, 0, 1, 32'h08);
        vecs[3]  = mk(1, 32'h010000EF, 32'h0C, 1, 0, 1, 1, 32'h010000EF, 32'h0C, IMM_J, 0, 1, 32'h10);
        vecs[4]  = mk(0, 32'h0,        32'h00, 1, 0, 0, 1, 32'h010000EF, 32'h0C, IMM_I, 0, 0, 32'h0);
        // Stall: fill to two, hold head for 5 cycles, then drain and accept the third.
        vecs[5]  = mk(1, 32'h00100093, 32'h10, 0, 0, 1, 1, 32'h00100093, 32'h10, IMM_I, 0, 0, 32'h0);
        vecs[6]  = mk(1, 32'h00200113, 32'h14, 0, 0, 1, 0, 32'h00100093, 32'h10, IMM_I, 0, 0, 32'h0);
        for (int k = 7; k <= 11; k++)
            vecs[k] = mk(1, 32'h00300193, 32'h18, 0, 0, 1, 0, 32'h00100093, 32'h10, IMM_I, 0, 0, 32'h0);
        vecs[12] = mk(1, 32'h00300193, 32'h18, 1, 0, 1, 1, 32'h00200113, 32'h14, IMM_I, 0, 0, 32'h0);
        vecs[13] = mk(1, 32'h00300193, 32'h18, 1, 0, 1, 1, 32'h00300193, 32'h18, IMM_I, 0, 0, 32'h0);
        vecs[14] = mk(0, 32'h0,        32'h00, 1, 0, 0, 1, 32'h00300193, 32'h18, IMM_I, 0, 0, 32'h0);
        // Flush with full queue and a concurrent push request.
        vecs[15] = mk(1, 32'h00400213, 32'h20, 0, 0, 1, 1, 32'h00400213, 32'h20, IMM_I, 0, 0, 32'h0);
        vecs[16] = mk(1, 32'h00500293, 32'h24, 0, 0, 1, 0, 32'h00400213, 32'h20, IMM_I, 0, 0, 32'h0);
        vecs[17] = mk(1, 32'h00600313, 32'h28, 0, 1, 0, 1, 32'h00400213, 32'h20, IMM_I, 0, 0, 32'h0);
        vecs[18] = mk(0, 32'h0,        32'h00, 1, 0, 0, 1, 32'h00400213, 32'h20, IMM_I, 0, 0, 32'h0);
        // Opcode classes: LUI/AUIPC illegal, R-type/load/jalr legal.
        vecs[19] = mk(1, 32'h00000037, 32'h30, 0, 0, 1, 1, 32'h00000037, 32'h30, IMM_I, 1, 0, 32'h0);
        vecs[20] = mk(0, 32'h0,        32'h00, 1, 0, 0, 1, 32'h00000037, 32'h30, IMM_I, 0, 0, 32'h0);
        vecs[21] = mk(1, 32'h002081B3, 32'h34, 1, 0, 1, 1, 32'h002081B3, 32'h34, IMM_I, 0, 0, 32'h0);
        vecs[22] = mk(1, 32'h00000017, 32'h38, 1, 0, 1, 1, 32'h00000017, 32'h38, IMM_I, 1, 0, 32'h0);
        vecs[23] = mk(1, 32'h0000A083, 32'h3C, 1, 0, 1, 1, 32'h0000A083, 32'h3C, IMM_I, 0, 0, 32'h0);
        vecs[24] = mk(1, 32'h000080E7, 32'h40, 1, 0, 1, 1, 32'h000080E7, 32'h40, IMM_I, 0, 0, 32'h0);
        vecs[25] = mk(0, 32'h0,        32'h00, 1, 0, 0, 1, 32'h000080E7, 32'h40, IMM_I, 0, 0, 32'h0);
        // Flush with one entry, a pop and a push all in the same cycle.
        vecs[26] = mk(1, 32'h00700393, 32'h44, 0, 0, 1, 1, 32'h00700393, 32'h44, IMM_I, 0, 0, 32'h0);
        vecs[27] = mk(1, 32'h00800413, 32'h48, 1, 1, 0, 1, 32'h00700393, 32'h44, IMM_I, 0, 0, 32'h0);
        vecs[28] = mk(0, 32'h0,        32'h00, 1, 0, 0, 1, 32'h00700393, 32'h44, IMM_I, 0, 0, 32'h0);

        rst_n = 1'b0;
        drive(0, 32'h0, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        chk("rst_out_valid", -1, {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", -1, {31'd0, in_ready}, 32'd0);
        chk("rst_out_instr", -1, out_instr, 32'd0);
        chk("rst_out_pc", -1, out_pc, 32'd0);
        chk("rst_imm_src", -1, {30'd0, out_imm_src}, {30'd0, IMM_I});
        chk("rst_illegal", -1, {31'd0, out_illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_before_edge", -1, {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("rel_in_ready", -1, {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].ins, vecs[i].pc, vecs[i].ordy, vecs[i].fl);
            @(posedge clk);
            #1;
            $display("step %0d: iv=%0d instr=%08h ordy=%0d fl=%0d -> ov=%0d ir=%0d out=%08h pc=%08h",
                     i, vecs[i].iv, vecs[i].ins, vecs[i].ordy, vecs[i].fl,
                     out_valid, in_ready, out_instr, out_pc);
            chk("out_valid", i, {31'd0, out_valid}, {31'd0, vecs[i].ev});
            chk("in_ready", i, {31'd0, in_ready}, {31'd0, vecs[i].erdy});
            chk("out_instr", i, out_instr, vecs[i].eins);
            chk("out_pc", i, out_pc, vecs[i].epc);
            if (vecs[i].ev) begin
                chk("out_imm_src", i, {30'd0, out_imm_src}, {30'd0, vecs[i].eimm});
                chk("out_illegal", i, {31'd0, out_illegal}, {31'd0, vecs[i].eill});
            end
            if (vecs[i].chk_imm)
                chk("imm_extend", i, imm_extend(out_instr, out_imm_src), vecs[i].eimmval);
        end

        // Asynchronous reset in the middle of a cycle with a full queue.
        @(negedge clk);
        drive(1, 32'h00900493, 32'h50, 0, 0);
        @(negedge clk);
        drive(1, 32'h00A00513, 32'h54, 0, 0);
        @(negedge clk);
        drive(0, 32'h0, 32'h0, 0, 0);
        #2;
        chk("full_out_valid", 100, {31'd0, out_valid}, 32'd1);
        chk("full_in_ready", 100, {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        $display("async reset mid-cycle: ov=%0d ir=%0d out=%08h", out_valid, in_ready, out_instr);
        chk("async_out_valid", 101, {31'd0, out_valid}, 32'd0);
        chk("async_in_ready", 101, {31'd0, in_ready}, 32'd0);
        chk("async_out_instr", 101, out_instr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 102, {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", 102, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        drive(1, 32'h00B00593, 32'h60, 1, 0);
        @(posedge clk);
        #1;
        $display("post-reset push: ov=%0d out=%08h pc=%08h", out_valid, out_instr, out_pc);
        chk("post_rst_push_valid", 103, {31'd0, out_valid}, 32'd1);
        chk("post_rst_push_instr", 103, out_instr, 32'h00B00593);
        chk("post_rst_push_pc", 103, out_pc, 32'h60);
        @(negedge clk);
        drive(0, 32'h0, 32'h0, 1, 0);
        @(posedge clk);
        #1;
        chk("post_rst_drain_valid", 104, {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_issue_ctrl.md
Name: id_issue_ctrl

Overview:
- Decode-stage issue controller for the RV32I pipeline. Sits between the fetch stage (IF) and the ID/EX register.
- Buffers fetched instructions in a 2-entry skid queue and pre-decodes the opcode into the `imm_src_e` select consumed by `imm_extend`.
- Flags unsupported opcodes and sequences IF→ID transfers with valid/ready handshakes.
- Handles pipeline flush on branch/jump redirect and downstream stall.

Parameters:
- XLEN, 32, data/PC width; only 32 is supported.
- DEPTH, 2, skid queue entries; only 2 is supported. The parameter exists for assertions.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, IF presents an instruction.
- in_ready, out, 1, controller can accept this cycle.
- in_instr, in, 32, fetched instruction word.
- in_pc, in, 32, PC of `in_instr`.
- out_valid, out, 1, head entry valid toward ID/EX.
- out_ready, in, 1, ID/EX accepts (low = EX stall).
- out_instr, out, 32, head instruction; drives `imm_extend.instr`.
- out_pc, out, 32, head PC.
- out_imm_src, out, imm_src_e, head immediate select; drives `imm_extend.imm_src`.
- out_illegal, out, 1, head opcode unsupported.
- flush, in, 1, redirect from EX; discard all buffered and incoming instructions.

Behaviour:
- Reset (rst_n low, asynchronous): count=0, out_valid=0, in_ready=0, out_instr=0, out_pc=0, out_imm_src=IMM_I, out_illegal=0. in_ready rises on the first clock edge after rst_n deasserts.
- Reset mid-operation: all entries are discarded immediately. No partial output is permitted.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Queue is FIFO. Outputs always reflect the head entry. Outputs are registered; no combinational in→out path.
- Latency: an instruction pushed at edge N is visible on out_* after edge N (one cycle), if the queue was empty.
- in_ready is registered and equals (next count < 2). When count=2 and a pop occurs, in_ready is 1 the following cycle, not the same cycle.
- Count transitions:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, head advances, tail written
  - neither: hold
- Pre-decode on push (opcode = instr[6:0]), stored per entry:
  - OP_ITYPE, OP_LOAD, OP_JALR → IMM_I
  - OP_STORE → IMM_S
  - OP_BRANCH → IMM_B
  - OP_JAL → IMM_J
  - OP_RTYPE → IMM_I (don't-care), illegal=0
  - any other opcode, including LUI/AUIPC → IMM_I, illegal=1
- Illegal entries are issued normally. The downstream stage traps on them.
- out_valid=0 ⇒ out_instr/out_pc hold their last values; out_imm_src and out_illegal are don't-care but must not be X.
- Flush:
  - Synchronous; takes priority over push and pop.
  - On the flush edge: count←0 and any simultaneous push is discarded.
  - out_valid=0 and in_ready=1 the next cycle.
  - A pop presented in the flush cycle still counts as accepted by ID/EX; EX is responsible for squashing it.
- Stall: with out_ready=0 and count=2, the head is held stable and in_ready=0 until a pop.
- Empty: out_valid=0; out_ready is ignored.

Optional Feature:
- Macro ID_ISSUE_PERF_EN.
- When defined, three extra output ports are added, each CNT_W bits, wrapping, reset to 0:
  - perf_stall_cycles: increments each cycle out_valid && !out_ready.
  - perf_flushed: increments by count (0–2) on each flush edge.
  - perf_illegal: increments on each pop with out_illegal=1.
- When undefined, the ports and logic are absent. Core behaviour is identical in both cases.

Test Plan:
- Reset then push 0x00508113 (addi x2,x1,5), pc=0x0, with out_ready=1 → next cycle out_valid=1, out_instr=0x00508113, out_imm_src=IMM_I, out_illegal=0. Feeding `imm_extend` yields 0x00000005.
- Back-to-back pushes 0x0430AA23 (sw x3,84(x1)), 0x00208463 (beq +8), 0x010000EF (jal +16) with out_ready=1 → issued in order, one per cycle, imm_src S/B/J. `imm_extend` outputs 0x54, 0x8, 0x10.
- Hold out_ready=0 and push 3 instructions → first two accepted, in_ready=0 after the second. Head stable for 5 cycles. Release → both pop in order, then the third is accepted.
- Queue holding 2 entries, assert flush together with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle instruction never appears.
- Push 0x00000037 (LUI) → out_illegal=1, out_imm_src=IMM_I. With ID_ISSUE_PERF_EN, perf_illegal=1 after the pop.
- Assert rst_n low asynchronously mid-cycle with count=2 → out_valid drops before the next edge, in_ready=0. After release, the first push is issued with 1-cycle latency.
